bitwise_reduce_accum: RTL and testbench

Parametrised, multi-channel bitwise reduction engine with a start/handshake front end. Each accepted beat carries CHANNELS words of WIDTH bits. The words are reduced bitwise (OR, AND or XOR), and the beat result is folded into a running accumulator over a programmed number of beats. The final value is presented on a valid/ready output. The block is the sequential, mode-selectable successor of the fixed 8-bit three-input OR gate in the counter datapath.

---
 rtl/bitwise_reduce_accum.sv | 137 +++++++++++++
 tb/tb_bitwise_reduce_accum.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_reduce_accum.sv
// Multi-channel bitwise reduction engine (OR/AND/XOR) folded over a programmed
// number of beats, with a start front end and a valid/ready result port.
`timescale 1ns/1ps

module bitwise_reduce_accum #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 3,
   parameter int LEN_W    = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [1:0]                mode,
   input  logic [LEN_W-1:0]          len,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          result,
   output logic                      busy,
   output logic [LEN_W-1:0]          beat_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_AND = 2'b01;
   localparam logic [1:0] MODE_XOR = 2'b10;

   // Reserved mode 11 behaves as OR.
   function automatic logic [WIDTH-1:0] f_op(input logic [1:0]       m,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
      case (m)
         MODE_AND: f_op = a & b;
         MODE_XOR: f_op = a ^ b;
         default:  f_op = a | b;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] f_identity(input logic [1:0] m);
      f_identity = (m == MODE_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
   endfunction

   state_t           r_state;
   state_t           w_state_next;
   logic [1:0]       r_mode;
   logic [LEN_W-1:0] r_len;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic [LEN_W-1:0] r_beat_cnt;

   logic [WIDTH-1:0] w_beat_red;
   logic [WIDTH-1:0] w_fold;
   logic [LEN_W-1:0] w_cnt_next;
   logic             w_accept;
   logic             w_last;

   always_comb begin
      w_beat_red = in_data[0 +: WIDTH];
      for (int k = 1; k < CHANNELS; k++) begin
         w_beat_red = f_op(r_mode, w_beat_red, in_data[k*WIDTH +: WIDTH]);
      end
   end

   assign w_accept   = in_valid && (r_state == S_ACCUM);
   assign w_fold     = f_op(r_mode, r_acc, w_beat_red);
   assign w_cnt_next = r_beat_cnt + LEN_W'(1);
   assign w_last     = w_accept && (w_cnt_next == r_len);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // NOTE: next state is defaulted first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = (len != '0) ? S_ACCUM : S_DONE;
         end
         S_ACCUM: begin
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            if (out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode     <= 2'b00;
         r_len      <= '0;
         r_acc      <= '0;
         r_result   <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode     <= mode;
                  r_len      <= len;
                  r_acc      <= f_identity(mode);
                  r_beat_cnt <= '0;
                  if (len == '0) r_result <= f_identity(mode);
               end
            end
            S_ACCUM: begin
               if (w_accept) begin
                  r_acc      <= w_fold;
                  r_beat_cnt <= w_cnt_next;
                  if (w_last) r_result <= w_fold;
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake outputs are pure decodes of the state register.
   assign in_ready  = (r_state == S_ACCUM);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign result    = r_result;
   assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_bitwise_reduce_accum.sv
// Scoreboard bench for bitwise_reduce_accum: stimulus queues expected results,
// a negedge monitor pops and compares on every output handshake.
`timescale 1ns/1ps

module tb_bitwise_reduce_accum;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 3;
   localparam int LEN_W    = 4;

   localparam logic [1:0] M_OR  = 2'b00;
   localparam logic [1:0] M_AND = 2'b01;
   localparam logic [1:0] M_XOR = 2'b10;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      start;
   logic [1:0]                mode;
   logic [LEN_W-1:0]          len;
   logic                      in_valid;
   logic                      in_ready;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          result;
   logic                      busy;
   logic [LEN_W-1:0]          beat_cnt;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] exp_q[$];

   bitwise_reduce_accum #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy),
      .beat_cnt  (beat_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: the handshake completes at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result_pending", exp_q.size(), 1);
         end else begin
            automatic logic [WIDTH-1:0] e = exp_q.pop_front();
            check("result", result, e);
         end
      end
   end

   // Mode/len are scrambled right after start to prove they were latched.
   task automatic start_job(input logic [1:0] m, input logic [LEN_W-1:0] l);
      start = 1'b1;
      mode  = m;
      len   = l;
      @(posedge clk); #1;
      start = 1'b0;
      mode  = ~m;
      len   = ~l;
   endtask

   task automatic beat(input logic [7:0] c, input logic [7:0] b, input logic [7:0] a);
      in_valid = 1'b1;
      in_data  = {c, b, a};
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 24'hFFFFFF;
   endtask

   task automatic finish_job(input string name);
      int n = 0;
      out_ready = 1'b1;
      while (busy && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_back_to_idle"}, busy, 0);
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      mode      = 2'b00;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #3;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_result", result, 0);
      check("rst_beat_cnt", beat_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // OR, single beat
      exp_q.push_back(8'h07);
      start_job(M_OR, 4'd1);
      check("t1_in_ready", in_ready, 1);
      check("t1_beat_cnt0", beat_cnt, 0);
      beat(8'h04, 8'h02, 8'h01);
      check("t1_out_valid", out_valid, 1);
      check("t1_in_ready_done", in_ready, 0);
      finish_job("t1");
      check("t1_result_held_idle", result, 8'h07);
      check("t1_out_valid_idle", out_valid, 0);

      // AND, two beats
      exp_q.push_back(8'h30);
      start_job(M_AND, 4'd2);
      beat(8'hFF, 8'hF0, 8'hFC);
      check("t2_beat_cnt1", beat_cnt, 1);
      check("t2_result_held_accum", result, 8'h07);
      check("t2_no_valid_yet", out_valid, 0);
      beat(8'h3C, 8'hFF, 8'hFF);
      check("t2_beat_cnt2", beat_cnt, 2);
      check("t2_out_valid", out_valid, 1);
      finish_job("t2");

      // XOR, three back-to-back beats: 0x33 ^ 0x0F ^ 0x81 = 0xBD
      exp_q.push_back(8'hBD);
      start_job(M_XOR, 4'd3);
      beat(8'h11, 8'h22, 8'h00);
      beat(8'h0F, 8'h00, 8'h00);
      beat(8'h80, 8'h01, 8'h00);
      check("t3_out_valid", out_valid, 1);
      finish_job("t3");

      // Same job with two idle cycles between beats
      exp_q.push_back(8'hBD);
      start_job(M_XOR, 4'd3);
      beat(8'h11, 8'h22, 8'h00);
      for (int g = 0; g < 2; g++) begin
         @(posedge clk); #1;
         check("t3g_cnt_hold1", beat_cnt, 1);
      end
      beat(8'h0F, 8'h00, 8'h00);
      for (int g = 0; g < 2; g++) begin
         @(posedge clk); #1;
         check("t3g_cnt_hold2", beat_cnt, 2);
         check("t3g_no_valid", out_valid, 0);
      end
      beat(8'h80, 8'h01, 8'h00);
      finish_job("t3g");

      // Backpressure in DONE with start/mode/len activity
      exp_q.push_back(8'h5A);
      start_job(M_OR, 4'd1);
      beat(8'h00, 8'h5A, 8'h00);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         mode  = 2'(i);
         len   = LEN_W'(i);
         @(posedge clk); #1;
         check("t4_out_valid", out_valid, 1);
         check("t4_in_ready", in_ready, 0);
         check("t4_result", result, 8'h5A);
      end
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      out_ready = 1'b0;
      check("t4_idle_after_release", busy, 0);
      @(posedge clk); #1;
      check("t4_no_new_job", busy, 0);

      // len = 0
      exp_q.push_back(8'h00);
      start_job(M_OR, 4'd0);
      check("t5_or_valid", out_valid, 1);
      check("t5_or_in_ready", in_ready, 0);
      finish_job("t5_or");
      exp_q.push_back(8'hFF);
      start_job(M_AND, 4'd0);
      check("t5_and_valid", out_valid, 1);
      finish_job("t5_and");

      // Reset mid-job, then a clean job
      start_job(M_XOR, 4'd3);
      beat(8'hAA, 8'h55, 8'h0F);
      check("t6_cnt_before_rst", beat_cnt, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_in_ready", in_ready, 0);
      check("t6_rst_out_valid", out_valid, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_result", result, 0);
      check("t6_rst_beat_cnt", beat_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(8'h80);
      start_job(M_OR, 4'd1);
      beat(8'h00, 8'h00, 8'h80);
      finish_job("t6_after_rst");

      repeat (2) @(posedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
